// File: rtl/alu_cmd_issuer_if.sv
// Host-facing command and response channels of alu_cmd_issuer.
// The host drives commands and accepts tagged responses over valid/ready.
interface alu_cmd_issuer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_cin;
    logic [3:0] cmd_op;
    logic [3:0] cmd_tag;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_f;
    logic [5:0] rsp_flags;
    logic       rsp_err;
    logic [3:0] rsp_tag;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_cin, cmd_op, cmd_tag, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_f, rsp_flags, rsp_err, rsp_tag
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_cin, cmd_op, cmd_tag, rsp_ready,
        output cmd_ready, rsp_valid, rsp_f, rsp_flags, rsp_err, rsp_tag
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Buffers ALU commands, drives a registered-latency ALU and returns tagged results.
// Illegal opcodes (op[3:2]==01) are answered with an error response without touching the ALU.
module alu_cmd_issuer #(
    parameter int CMD_DEPTH = 4,
    parameter int ALU_LAT   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    alu_cmd_issuer_if.slave        host,
    output logic [7:0]             alu_a,
    output logic [7:0]             alu_b,
    output logic                   alu_cin,
    output logic [3:0]             alu_s,
    input  logic [7:0]             alu_f,
    input  logic                   alu_carry,
    input  logic                   alu_zero,
    input  logic                   alu_ovf,
    input  logic                   alu_eq,
    input  logic                   alu_gt,
    input  logic                   alu_lt,
    output logic                   busy,
    output logic [7:0]             ops_done
);
    localparam int PW = $clog2(CMD_DEPTH);
    localparam int CW = $clog2(ALU_LAT + 2);
    localparam logic [PW:0] PTR_ONE  = {{PW{1'b0}}, 1'b1};
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(CMD_DEPTH);

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [3:0] op;
        logic [3:0] tag;
    } cmd_t;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    cmd_t          fifo_mem_r [CMD_DEPTH];
    logic [PW:0]   wr_ptr_r, rd_ptr_r;
    logic [PW:0]   count_s, count_nxt_s;
    logic          empty_s, push_s, pop_s, slot_free_s;
    logic          issue_s, ill_s, cap_s, arith_s;
    cmd_t          head_s, cmd_in_s;
    state_t        state_r, state_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic [3:0]    tag_r;
    logic [5:0]    cap_flags_s;
    logic          cmd_ready_r, busy_r, rsp_valid_r, rsp_err_r;
    logic [7:0]    alu_a_r, alu_b_r, rsp_f_r, ops_done_r;
    logic          alu_cin_r;
    logic [3:0]    alu_s_r, rsp_tag_r;
    logic [5:0]    rsp_flags_r;

    assign count_s     = wr_ptr_r - rd_ptr_r;
    assign empty_s     = (count_s == {(PW + 1){1'b0}});
    assign head_s      = fifo_mem_r[rd_ptr_r[PW-1:0]];
    assign cmd_in_s    = '{a: host.cmd_a, b: host.cmd_b, cin: host.cmd_cin,
                           op: host.cmd_op, tag: host.cmd_tag};
    assign push_s      = host.cmd_valid && cmd_ready_r;
    assign slot_free_s = !rsp_valid_r || host.rsp_ready;
    // Non-arithmetic ops carry no meaningful ALU flags, so only zero survives, recomputed from F.
    assign arith_s     = (alu_s_r[3:2] == 2'b00);
    assign cap_flags_s = arith_s ? {alu_ovf, alu_carry, alu_zero, alu_gt, alu_eq, alu_lt}
                                 : {2'b00, (alu_f == 8'h00), 3'b000};

    // Issue/wait sequencing and the one-cycle pop/issue/capture strobes.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        pop_s       = 1'b0;
        issue_s     = 1'b0;
        ill_s       = 1'b0;
        cap_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s && slot_free_s) begin
                    pop_s = 1'b1;
                    if (head_s.op[3:2] == 2'b01) begin
                        ill_s = 1'b1;
                    end else begin
                        issue_s     = 1'b1;
                        cnt_nxt_s   = CW'(ALU_LAT);
                        state_nxt_s = ST_WAIT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == {CW{1'b0}}) begin
                    cap_s       = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r - CW'(1);
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FIFO occupancy after this edge, used for the registered ready/busy outputs.
    always_comb begin
        count_nxt_s = count_s;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_s + PTR_ONE;
            2'b01:   count_nxt_s = count_s - PTR_ONE;
            default: count_nxt_s = count_s;
        endcase
    end

    // State register and latency counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Command FIFO storage, pointers and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CMD_DEPTH; i++) fifo_mem_r[i] <= '0;
            wr_ptr_r    <= {(PW + 1){1'b0}};
            rd_ptr_r    <= {(PW + 1){1'b0}};
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r[PW-1:0]] <= cmd_in_s;
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
            cmd_ready_r <= (count_nxt_s != FULL_CNT);
            busy_r      <= (state_nxt_s == ST_WAIT) || (count_nxt_s != {(PW + 1){1'b0}});
        end
    end

    // ALU operand registers change only on issue, so they hold through WAIT and idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_r   <= 8'h00;
            alu_b_r   <= 8'h00;
            alu_cin_r <= 1'b0;
            alu_s_r   <= 4'h0;
            tag_r     <= 4'h0;
        end else if (issue_s) begin
            alu_a_r   <= head_s.a;
            alu_b_r   <= head_s.b;
            alu_cin_r <= head_s.cin;
            alu_s_r   <= head_s.op;
            tag_r     <= head_s.tag;
        end
    end

    // Response slot: loads come only when the slot is free, otherwise it holds until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_f_r     <= 8'h00;
            rsp_flags_r <= 6'b000000;
            rsp_tag_r   <= 4'h0;
            ops_done_r  <= 8'h00;
        end else if (ill_s) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b1;
            rsp_f_r     <= 8'h00;
            rsp_flags_r <= 6'b000000;
            rsp_tag_r   <= head_s.tag;
        end else if (cap_s) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b0;
            rsp_f_r     <= alu_f;
            rsp_flags_r <= cap_flags_s;
            rsp_tag_r   <= tag_r;
            ops_done_r  <= ops_done_r + 8'd1;
        end else if (rsp_valid_r && host.rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end
    end

    assign host.cmd_ready = cmd_ready_r;
    assign host.rsp_valid = rsp_valid_r;
    assign host.rsp_f     = rsp_f_r;
    assign host.rsp_flags = rsp_flags_r;
    assign host.rsp_err   = rsp_err_r;
    assign host.rsp_tag   = rsp_tag_r;
    assign alu_a          = alu_a_r;
    assign alu_b          = alu_b_r;
    assign alu_cin        = alu_cin_r;
    assign alu_s          = alu_s_r;
    assign busy           = busy_r;
    assign ops_done       = ops_done_r;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a two-stage stub ALU and a response scoreboard.
module tb_alu_cmd_issuer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_cmd_issuer_if host ();
    logic [7:0] alu_a, alu_b, alu_f, ops_done;
    logic       alu_cin, alu_carry, alu_zero, alu_ovf, alu_eq, alu_gt, alu_lt, busy;
    logic [3:0] alu_s;

    alu_cmd_issuer #(.CMD_DEPTH(4), .ALU_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .host(host),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_s(alu_s),
        .alu_f(alu_f), .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
        .alu_eq(alu_eq), .alu_gt(alu_gt), .alu_lt(alu_lt),
        .busy(busy), .ops_done(ops_done)
    );

    // Stub ALU result: add for op[3:2]==00, else AND/XOR with deliberately noisy flags.
    function automatic logic [13:0] stub_calc(input logic [7:0] a, input logic [7:0] b,
                                              input logic cin, input logic [3:0] s);
        logic [8:0] sum;
        logic [7:0] f;
        logic       c, v, z;
        if (s[3:2] == 2'b00) begin
            sum = {1'b0, a} + {1'b0, b} + {8'h00, cin};
            f   = sum[7:0];
            c   = sum[8];
            v   = (a[7] == b[7]) && (f[7] != a[7]);
            z   = (f == 8'h00);
        end else begin
            f = s[2] ? (a ^ b) : (a & b);
            c = 1'b1;
            v = 1'b1;
            z = 1'b0;
        end
        return {f, v, c, z, (a > b), (a == b), (a < b)};
    endfunction

    logic [13:0] stg1_r, stg2_r;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg1_r <= 14'd0;
            stg2_r <= 14'd0;
        end else begin
            stg1_r <= stub_calc(alu_a, alu_b, alu_cin, alu_s);
            stg2_r <= stg1_r;
        end
    end
    assign {alu_f, alu_ovf, alu_carry, alu_zero, alu_gt, alu_eq, alu_lt} = stg2_r;

    // Expected response {f, flags, err, tag} for a command.
    function automatic logic [18:0] exp_rsp(input logic [7:0] a, input logic [7:0] b,
                                            input logic cin, input logic [3:0] op,
                                            input logic [3:0] tag);
        logic [13:0] r;
        logic [5:0]  fl;
        if (op[3:2] == 2'b01) return {8'h00, 6'h00, 1'b1, tag};
        r = stub_calc(a, b, cin, op);
        if (op[3:2] == 2'b00) fl = r[5:0];
        else                  fl = {2'b00, (r[13:6] == 8'h00), 3'b000};
        return {r[13:6], fl, 1'b0, tag};
    endfunction

    int          total = 0;
    int          bad = 0;
    int          legal_cnt = 0;
    int          sent;
    logic        acc;
    logic [18:0] sb [$];

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One clock: record handshakes seen before the edge, then move to #1 after it.
    task automatic step();
        logic [18:0] o;
        logic [18:0] e;
        if (host.cmd_valid && host.cmd_ready) begin
            sb.push_back(exp_rsp(host.cmd_a, host.cmd_b, host.cmd_cin, host.cmd_op, host.cmd_tag));
            if (host.cmd_op[3:2] != 2'b01) legal_cnt++;
        end
        if (host.rsp_valid && host.rsp_ready) begin
            o = {host.rsp_f, host.rsp_flags, host.rsp_err, host.rsp_tag};
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL rsp_spurious: observed=%0h expected=none", o);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("rsp_sb", 32'(o), 32'(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [3:0] op, input logic [3:0] tag);
        host.cmd_valid = 1'b1;
        host.cmd_a     = a;
        host.cmd_b     = b;
        host.cmd_cin   = cin;
        host.cmd_op    = op;
        host.cmd_tag   = tag;
    endtask

    initial begin
        rst_n = 1'b0;
        host.rsp_ready = 1'b0;
        drive(8'h00, 8'h00, 1'b0, 4'h0, 4'h0);
        host.cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(host.cmd_ready), 32'h0);
        check("rst_rsp_valid", 32'(host.rsp_valid), 32'h0);
        check("rst_alu_a", 32'(alu_a), 32'h0);
        check("rst_ops_done", 32'(ops_done), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        step();
        check("rel_cmd_ready", 32'(host.cmd_ready), 32'h1);

        // single add: push at edge 0, response after edge 4
        host.rsp_ready = 1'b1;
        drive(8'h3C, 8'h05, 1'b1, 4'b0000, 4'd3);
        step();
        host.cmd_valid = 1'b0;
        step();
        check("t1_alu_s", 32'(alu_s), 32'h0);
        check("t1_alu_a", 32'(alu_a), 32'h3C);
        check("t1_alu_b", 32'(alu_b), 32'h05);
        check("t1_alu_cin", 32'(alu_cin), 32'h1);
        check("t1_busy", 32'(busy), 32'h1);
        step();
        step();
        check("t1_early", 32'(host.rsp_valid), 32'h0);
        step();
        check("t1_valid", 32'(host.rsp_valid), 32'h1);
        check("t1_f", 32'(host.rsp_f), 32'h42);
        check("t1_tag", 32'(host.rsp_tag), 32'h3);
        check("t1_err", 32'(host.rsp_err), 32'h0);
        check("t1_ops", 32'(ops_done), 32'h1);
        step();
        check("t1_drop", 32'(host.rsp_valid), 32'h0);

        // illegal op answered one edge after the pop
        drive(8'h11, 8'h22, 1'b0, 4'b0100, 4'd7);
        step();
        host.cmd_valid = 1'b0;
        step();
        check("t2_valid", 32'(host.rsp_valid), 32'h1);
        check("t2_err", 32'(host.rsp_err), 32'h1);
        check("t2_f", 32'(host.rsp_f), 32'h0);
        check("t2_flags", 32'(host.rsp_flags), 32'h0);
        check("t2_tag", 32'(host.rsp_tag), 32'h7);
        check("t2_alu_a", 32'(alu_a), 32'h3C);
        check("t2_ops", 32'(ops_done), 32'h1);
        step();

        // logic op: stub carry forced high must be masked, zero recomputed
        drive(8'hF0, 8'h0F, 1'b1, 4'b1000, 4'd9);
        step();
        host.cmd_valid = 1'b0;
        repeat (4) step();
        check("t3_valid", 32'(host.rsp_valid), 32'h1);
        check("t3_f", 32'(host.rsp_f), 32'h0);
        check("t3_flags", 32'(host.rsp_flags), 32'h08);
        check("t3_ops", 32'(ops_done), 32'h2);
        step();

        // backpressure: one held response, then fill the FIFO
        host.rsp_ready = 1'b0;
        drive(8'h10, 8'h20, 1'b0, 4'b0000, 4'd1);
        step();
        host.cmd_valid = 1'b0;
        repeat (4) step();
        check("t4_first", 32'(host.rsp_valid), 32'h1);
        for (int i = 0; i < 4; i++) begin
            drive(8'(8'h21 * i + 8'h07), 8'(8'h13 + i), 1'(i), (i == 2) ? 4'b0110 : 4'(4 * i + 1),
                  4'(i + 2));
            check("t4_ready", 32'(host.cmd_ready), 32'h1);
            step();
        end
        host.cmd_valid = 1'b0;
        check("t4_full", 32'(host.cmd_ready), 32'h0);
        repeat (3) step();
        check("t4_hold_v", 32'(host.rsp_valid), 32'h1);
        check("t4_hold_tag", 32'(host.rsp_tag), 32'h1);
        check("t4_hold_f", 32'(host.rsp_f), 32'h30);
        host.rsp_ready = 1'b1;
        for (int n = 0; n < 200 && sb.size() != 0; n++) step();
        check("t4_drained", 32'(sb.size()), 32'h0);
        repeat (3) step();
        check("t4_idle", 32'(busy), 32'h0);
        check("t4_ops", 32'(ops_done), 32'(legal_cnt[7:0]));

        // reset during WAIT discards the op
        drive(8'h01, 8'h02, 1'b0, 4'b0000, 4'hA);
        step();
        host.cmd_valid = 1'b0;
        step();
        step();
        check("t5_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("t5_rsp_valid", 32'(host.rsp_valid), 32'h0);
        check("t5_alu_a", 32'(alu_a), 32'h0);
        check("t5_ops", 32'(ops_done), 32'h0);
        check("t5_busy0", 32'(busy), 32'h0);
        check("t5_ready0", 32'(host.cmd_ready), 32'h0);
        sb.delete();
        legal_cnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("t5_ready", 32'(host.cmd_ready), 32'h1);
        repeat (6) step();
        check("t5_no_rsp", 32'(host.rsp_valid), 32'h0);

        // 256 random legal ops with random backpressure
        sent = 0;
        for (int n = 0; n < 20000 && (sent < 256 || sb.size() != 0); n++) begin
            host.rsp_ready = ($urandom_range(0, 3) != 0);
            if (!host.cmd_valid && sent < 256) begin
                case ($urandom_range(0, 2))
                    0:       drive(8'($urandom), 8'($urandom), 1'($urandom), {2'b00, 2'($urandom)}, 4'(sent));
                    1:       drive(8'($urandom), 8'($urandom), 1'($urandom), {2'b10, 2'($urandom)}, 4'(sent));
                    default: drive(8'($urandom), 8'($urandom), 1'($urandom), {2'b11, 2'($urandom)}, 4'(sent));
                endcase
            end
            acc = host.cmd_valid && host.cmd_ready;
            step();
            if (acc) begin
                sent++;
                host.cmd_valid = 1'b0;
            end
        end
        check("t6_sent", 32'(sent), 32'd256);
        check("t6_drained", 32'(sb.size()), 32'h0);
        host.rsp_ready = 1'b1;
        repeat (3) step();
        check("t6_wrap", 32'(ops_done), 32'h0);
        check("t6_idle", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end
endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Command-side driver for the 8-bit structural ALU: buffers operation commands, drives the ALU's A/B/cin/s inputs, waits out the ALU's registered latency, then captures the result and flags.
- Returns each result as a tagged response over valid/ready.
- Sits between a host/sequencer and one ALU instance; owns all ALU input timing, so hosts never handle ALU pipeline depth.

Parameters:
- CMD_DEPTH, 4: command FIFO entries (power of two, ≥2).
- ALU_LAT, 2: clock edges between alu_* outputs changing and ALU F register holding the result.

Ports:
- clk  in  1  rising-edge clock, shared with the ALU.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept a command (= not full).
- cmd_a  in  8  operand A.
- cmd_b  in  8  operand B.
- cmd_cin  in  1  carry in.
- cmd_op  in  4  ALU select s.
- cmd_tag  in  4  echoed in the response.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  host accepts the response.
- rsp_f  out  8  captured result.
- rsp_flags  out  6  {overflow, carry, zero, a_gt_b, a_eq_b, a_lt_b}.
- rsp_err  out  1  illegal opcode, no ALU operation performed.
- rsp_tag  out  4  tag of the command.
- alu_a, alu_b  out  8  registered ALU operands.
- alu_cin  out  1  registered ALU carry in.
- alu_s  out  4  registered ALU select.
- alu_f  in  8  ALU F.
- alu_carry, alu_zero, alu_ovf, alu_eq, alu_gt, alu_lt  in  1 each  ALU flags.
- busy  out  1  high in WAIT or when FIFO non-empty.
- ops_done  out  8  completed legal operations, wraps 255→0.

Behaviour:
- Reset (async, rst_n=0): FIFO empty; state IDLE; all outputs 0; cmd_ready becomes 1 after release. An in-flight op is discarded with no response.
- FIFO: push on cmd_valid&&cmd_ready. A command is never popped in its push cycle. When full, cmd_ready=0. Push and pop in the same cycle when not full are both honoured.
- slot_free = !rsp_valid || rsp_ready. A response transfer occurs on rsp_valid&&rsp_ready.
- IDLE, FIFO non-empty, slot_free:
  - Pop the head.
  - Legal op (op[3:2] != 01): load alu_* registers from the command at this edge, latch the tag, set cnt=ALU_LAT, go to WAIT.
  - Illegal op (op[3:2]==01): no alu_* change; at this edge load rsp_err=1, rsp_f=0, rsp_flags=0, rsp_tag, rsp_valid=1; stay in IDLE.
- WAIT: decrement cnt each edge. At the edge where cnt==0:
  - Capture alu_f and flags into rsp_*, with rsp_err=0.
  - Set rsp_valid=1, increment ops_done, return to IDLE.
  - For non-arithmetic ops (op[3:2]!=00), overflow/carry/gt/eq/lt are forced to 0; zero is recomputed as (alu_f==0).
- Latency: command pushed at edge k → earliest issue at edge k+1 → response valid after edge k+ALU_LAT+2 (k+4 by default).
- alu_* outputs hold their last issued values while idle. They never change during WAIT.
- rsp_* hold stable while rsp_valid && !rsp_ready. rsp_valid clears on transfer unless a new response loads at the same edge. Back-to-back responses are legal.
- Backpressure: no pop while !slot_free. WAIT is never entered with the slot blocked, so captures never overwrite an unaccepted response.
- ops_done counts only legal completions and wraps modulo 256.
- Reset asserted during WAIT: immediate clear, no partial response.

Test Plan:
- Single op against a stub ALU (ALU_LAT=2, F=A+B+cin registered): push A=0x3C, B=0x05, cin=1, op=0000, tag=3 at edge 0. Required: alu_s=0000 after edge 1; rsp_valid after edge 4 with rsp_f=0x42, tag=3, err=0; ops_done=1.
- Illegal op=0100, tag=7 with the FIFO otherwise empty. Required: rsp_valid with err=1, f=0, flags=0 one edge after the pop; alu_* unchanged; ops_done unchanged.
- Fill the FIFO with 4 commands while rsp_ready=0. Required: cmd_ready=0 after the 4th push; only the first response appears and is held stable. Release rsp_ready; all responses drain in push order with tags matching.
- Logic op op=1000 with a stub returning 0x00 and stub carry=1. Required: rsp_flags carry=0, zero=1.
- Assert rst_n=0 mid-WAIT. Required: all outputs 0 immediately, no response after release, cmd_ready=1.
- 256 legal ops. Required: ops_done wraps to 0; no response lost or duplicated.
